pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives freeze and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers, and a bubble into MEM/WB.
- Resolves load-use and RAW hazards, taken-branch flushes and multi-cycle data-memory waits, with fixed priority.
- Tracks memory-wait state with a timeout watchdog and keeps saturating performance counters.

Parameters:
FORWARD_EN, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EX or MEM
MEM_TIMEOUT, 255, consecutive wait cycles before mem_timeout is raised
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  4  ID source register Rn
id_src2  in  4  ID source register Rm/Rd
id_uses_src1  in  1  instruction reads src1
id_uses_src2  in  1  instruction reads src2
ex_dest  in  4  EX-stage destination register
ex_wb_en  in  1  EX instruction writes back
ex_mem_read  in  1  EX instruction is a load
mem_dest  in  4  MEM-stage destination register
mem_wb_en  in  1  MEM instruction writes back
branch_taken  in  1  EX-stage branch resolved taken
mem_req  in  1  MEM stage has an access in flight
mem_ready  in  1  memory completes the access this cycle
pc_freeze  out  1  hold PC
if_id_freeze  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to a NOP
id_ex_freeze  out  1  hold ID/EX
id_ex_flush  out  1  load a bubble into ID/EX (all control bits 0)
ex_mem_freeze  out  1  hold EX/MEM
mem_wb_flush  out  1  load a bubble into MEM/WB
wait_state  out  1  1 while in MEM_WAIT
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  cycles with pc_freeze=1, saturating
flush_events  out  CNT_W  cycles with a branch flush, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; wait_cnt, stall_cycles, flush_events and mem_timeout all 0.
  - While rst=0, all freeze outputs are 0 and if_id_flush=id_ex_flush=mem_wb_flush=1.
- Hazard terms (combinational):
  - raw_ex = id_valid & ex_wb_en & ((id_uses_src1 & id_src1==ex_dest) | (id_uses_src2 & id_src2==ex_dest)).
  - raw_mem is the same expression using mem_dest and mem_wb_en.
  - FORWARD_EN=1: data_haz = raw_ex & ex_mem_read.
  - FORWARD_EN=0: data_haz = raw_ex | raw_mem.
- mem_stall = mem_req & ~mem_ready.
- Control outputs are combinational (Mealy). Priority, highest first:
  1. mem_stall: pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze and mem_wb_flush = 1. All other controls 0. A simultaneous branch_taken stays held in the frozen EX stage and is serviced after the wait.
  2. branch_taken: if_id_flush=id_ex_flush=1, no freezes. Exactly 2 wrong-path instructions are squashed.
  3. data_haz: pc_freeze=if_id_freeze=1, id_ex_flush=1. Load-use costs 1 cycle; with FORWARD_EN=0 a RAW costs up to 2 cycles.
  4. Otherwise all controls are 0.
- FSM (2 states):
  - RUN -> MEM_WAIT when mem_stall=1.
  - MEM_WAIT -> RUN on the edge where mem_ready=1. That cycle mem_stall=0, so priorities 2-4 apply and the pipeline advances.
  - Zero-wait access (mem_req & mem_ready in RUN) stays in RUN with no stall.
  - mem_req dropping without mem_ready while in MEM_WAIT also returns to RUN.
- wait_cnt:
  - Increments each cycle in MEM_WAIT, saturating at MEM_TIMEOUT; cleared on leaving MEM_WAIT.
  - mem_timeout is set when wait_cnt==MEM_TIMEOUT and stays set until reset. The wait itself continues.
- Counters: stall_cycles +1 per cycle with pc_freeze=1; flush_events +1 per cycle with priority-2 active. Both saturate at all ones with no wrap.
- Register 15 (PC) is compared like any other register index; there is no special case.

Decomposition:
- pipe_ctrl_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - REG_IDX_W=4;
  - the control-bundle struct (the 7 freeze/flush bits).
- One sub-module, hazard_detect: purely combinational raw_ex/raw_mem/data_haz generation, with FORWARD_EN passed down.
- The FSM, priority mux and counters live in the top level.

Test Plan:
- Load-use: ex_mem_read=1, ex_wb_en=1, ex_dest=3, id_src1=3, id_uses_src1=1 -> one cycle of pc_freeze, if_id_freeze and id_ex_flush; stall_cycles=1. Next cycle (bubble in EX) all controls 0.
- FORWARD_EN=0: ALU op with mem_dest=5, mem_wb_en=1, id_src2=5 -> stall asserted. Same inputs with FORWARD_EN=1 -> no stall.
- Branch: branch_taken=1 for 1 cycle -> if_id_flush=id_ex_flush=1, no freezes, flush_events=1.
- Memory wait with simultaneous branch: mem_req=1, mem_ready=0 for 4 cycles with branch_taken=1 ->
  - all four freezes and mem_wb_flush high for 4 cycles, wait_state=1;
  - on the mem_ready cycle, if_id_flush=id_ex_flush=1 and the FSM returns to RUN;
  - stall_cycles=4.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 for 20 cycles -> mem_timeout rises after 8 wait cycles and stays 1 after mem_ready returns. Cleared only by rst=0.
- Async reset mid-wait: drop rst in MEM_WAIT between clock edges -> state=RUN, counters and mem_timeout 0 immediately, flushes=1, freezes=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline stall/flush controller
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_freeze;
        logic id_ex_flush;
        logic ex_mem_freeze;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '0;
    // Reset drains the pipeline: every register pair loads a bubble, nothing holds.
    localparam ctrl_t CTRL_RESET = '{pc_freeze: 1'b0, if_id_freeze: 1'b0, if_id_flush: 1'b1,
                                     id_ex_freeze: 1'b0, id_ex_flush: 1'b1,
                                     ex_mem_freeze: 1'b0, mem_wb_flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational RAW / load-use hazard detection for the ID stage
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN = 1
) (
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_uses_src1,
    input  logic                 id_uses_src2,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 ex_wb_en,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 data_haz
);

    logic raw_ex;
    logic raw_mem;

    assign raw_ex  = id_valid & ex_wb_en &
                     ((id_uses_src1 & (id_src1 == ex_dest)) |
                      (id_uses_src2 & (id_src2 == ex_dest)));
    assign raw_mem = id_valid & mem_wb_en &
                     ((id_uses_src1 & (id_src1 == mem_dest)) |
                      (id_uses_src2 & (id_src2 == mem_dest)));

    // With forwarding only a load in EX cannot supply its result in time.
    generate
        if (FORWARD_EN != 0) begin : g_fwd
            assign data_haz = raw_ex & ex_mem_read;
        end else begin : g_nofwd
            assign data_haz = raw_ex | raw_mem;
        end
    endgenerate

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush priority controller with memory-wait FSM and perf counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_uses_src1,
    input  logic                 id_uses_src2,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 ex_wb_en,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_freeze,
    output logic                 if_id_freeze,
    output logic                 if_id_flush,
    output logic                 id_ex_freeze,
    output logic                 id_ex_flush,
    output logic                 ex_mem_freeze,
    output logic                 mem_wb_flush,
    output logic                 wait_state,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              data_haz;
    logic              mem_stall;
    logic              br_flush;
    ctrl_t             ctrl;
    ctrl_t             ctrl_out;

    hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_hazard_detect (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .ex_dest      (ex_dest),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_read  (ex_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .data_haz     (data_haz)
    );

    assign mem_stall = mem_req & ~mem_ready;
    assign br_flush  = branch_taken & ~mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Priority mux; a branch arriving during a memory wait stays frozen in EX until the wait ends.
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_NONE;
        case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (mem_stall) begin
            ctrl.pc_freeze     = 1'b1;
            ctrl.if_id_freeze  = 1'b1;
            ctrl.id_ex_freeze  = 1'b1;
            ctrl.ex_mem_freeze = 1'b1;
            ctrl.mem_wb_flush  = 1'b1;
        end else if (branch_taken) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
        end else if (data_haz) begin
            ctrl.pc_freeze     = 1'b1;
            ctrl.if_id_freeze  = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
        end
    end

    assign ctrl_out      = rst ? ctrl : CTRL_RESET;
    assign pc_freeze     = ctrl_out.pc_freeze;
    assign if_id_freeze  = ctrl_out.if_id_freeze;
    assign if_id_flush   = ctrl_out.if_id_flush;
    assign id_ex_freeze  = ctrl_out.id_ex_freeze;
    assign id_ex_flush   = ctrl_out.id_ex_flush;
    assign ex_mem_freeze = ctrl_out.ex_mem_freeze;
    assign mem_wb_flush  = ctrl_out.mem_wb_flush;
    assign wait_state    = (state_q == MEM_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (state_q == MEM_WAIT && state_d == MEM_WAIT) begin
                if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
            if (ctrl.pc_freeze && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (br_flush && flush_events != '1)       flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_src1, id_uses_src2;
    logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
    logic       ex_wb_en, ex_mem_read, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;

    logic        a_pcf, a_ifif, a_ifil, a_idef, a_idel, a_exmf, a_mwl, a_ws, a_to;
    logic [15:0] a_stall, a_flush;
    logic        b_pcf, b_ifif, b_ifil, b_idef, b_idel, b_exmf, b_mwl, b_ws, b_to;
    logic [3:0]  b_stall, b_flush;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MEM  = 7'b1101011;

    wire [6:0] ctl_a = {a_pcf, a_ifif, a_ifil, a_idef, a_idel, a_exmf, a_mwl};
    wire [6:0] ctl_b = {b_pcf, b_ifif, b_ifil, b_idef, b_idel, b_exmf, b_mwl};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_freeze(a_pcf), .if_id_freeze(a_ifif), .if_id_flush(a_ifil),
        .id_ex_freeze(a_idef), .id_ex_flush(a_idel), .ex_mem_freeze(a_exmf),
        .mem_wb_flush(a_mwl), .wait_state(a_ws), .mem_timeout(a_to),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    pipeline_hazard_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(8), .CNT_W(4)) dut_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_freeze(b_pcf), .if_id_freeze(b_ifif), .if_id_flush(b_ifil),
        .id_ex_freeze(b_idef), .id_ex_flush(b_idel), .ex_mem_freeze(b_exmf),
        .mem_wb_flush(b_mwl), .wait_state(b_ws), .mem_timeout(b_to),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_uses_src1 = 0; id_uses_src2 = 0;
        ex_dest = 0; ex_wb_en = 0; ex_mem_read = 0; mem_dest = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        id_valid = 1; ex_wb_en = 1; branch_taken = 1;
        #2;
        check("reset_ctl", 32'(ctl_a), 32'(C_RST));
        check("reset_ctl_b", 32'(ctl_b), 32'(C_RST));
        check("reset_wait", 32'(a_ws), 0);
        check("reset_cnt", 32'({a_stall, a_flush}), 0);
        check("reset_timeout", 32'(a_to), 0);

        // load-use: one-cycle bubble, then load moves on to MEM
        do_reset();
        id_valid = 1; id_src1 = 3; id_uses_src1 = 1;
        ex_dest = 3; ex_wb_en = 1; ex_mem_read = 1;
        #1;
        check("lu_ctl", 32'(ctl_a), 32'(C_LU));
        check("lu_ctl_b", 32'(ctl_b), 32'(C_LU));
        step();
        check("lu_stall", 32'(a_stall), 1);
        ex_wb_en = 0; ex_mem_read = 0; ex_dest = 0; mem_dest = 3; mem_wb_en = 1;
        #1;
        check("lu_after", 32'(ctl_a), 32'(C_NONE));
        check("lu_after_b", 32'(ctl_b), 32'(C_LU));
        step();
        check("lu_stall2", 32'(a_stall), 1);
        check("lu_stall2_b", 32'(b_stall), 2);

        // ALU RAW against MEM: only the non-forwarding controller stalls
        do_reset();
        id_valid = 1; id_src2 = 5; id_uses_src2 = 1; mem_dest = 5; mem_wb_en = 1;
        #1;
        check("raw_mem_fwd", 32'(ctl_a), 32'(C_NONE));
        check("raw_mem_nofwd", 32'(ctl_b), 32'(C_LU));
        id_uses_src2 = 0;
        #1;
        check("raw_unused_src", 32'(ctl_b), 32'(C_NONE));
        idle();
        id_valid = 1; id_src1 = 15; id_uses_src1 = 1; ex_dest = 15; ex_wb_en = 1; ex_mem_read = 1;
        #1;
        check("lu_r15", 32'(ctl_a), 32'(C_LU));
        id_valid = 0;
        #1;
        check("lu_invalid", 32'(ctl_a), 32'(C_NONE));
        check("lu_invalid_b", 32'(ctl_b), 32'(C_NONE));

        // branch flush, and branch outranking a simultaneous load-use
        do_reset();
        branch_taken = 1;
        #1;
        check("br_ctl", 32'(ctl_a), 32'(C_BR));
        step();
        check("br_count", 32'(a_flush), 1);
        check("br_nostall", 32'(a_stall), 0);
        id_valid = 1; id_src1 = 3; id_uses_src1 = 1; ex_dest = 3; ex_wb_en = 1; ex_mem_read = 1;
        #1;
        check("br_over_lu", 32'(ctl_a), 32'(C_BR));
        step();
        check("br_count2", 32'(a_flush), 2);

        // memory wait with a branch held in EX
        do_reset();
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mw_ctl", 32'(ctl_a), 32'(C_MEM));
            step();
            check("mw_state", 32'(a_ws), 1);
        end
        mem_ready = 1;
        #1;
        check("mw_release", 32'(ctl_a), 32'(C_BR));
        step();
        check("mw_exit", 32'(a_ws), 0);
        check("mw_stall", 32'(a_stall), 4);
        check("mw_flush", 32'(a_flush), 1);
        branch_taken = 0;
        #1;
        check("zero_wait", 32'(ctl_a), 32'(C_NONE));
        step();
        check("zero_wait_state", 32'(a_ws), 0);

        // mem_req withdrawn mid-wait
        do_reset();
        mem_req = 1;
        step();
        step();
        mem_req = 0;
        #1;
        check("drop_ctl", 32'(ctl_a), 32'(C_NONE));
        step();
        check("drop_state", 32'(a_ws), 0);

        // watchdog, counter saturation, then asynchronous reset mid-wait
        do_reset();
        mem_req = 1;
        repeat (8) step();
        check("to_early", 32'(a_to), 0);
        repeat (12) step();
        check("to_set", 32'(a_to), 1);
        check("to_set_b", 32'(b_to), 1);
        check("to_still_wait", 32'(a_ws), 1);
        check("stall_20", 32'(a_stall), 20);
        check("stall_sat_b", 32'(b_stall), 15);
        mem_ready = 1;
        step();
        mem_req = 0; mem_ready = 0;
        step();
        check("to_sticky", 32'(a_to), 1);
        check("to_run", 32'(a_ws), 0);
        mem_req = 1;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        check("arst_state", 32'(a_ws), 0);
        check("arst_to", 32'(a_to), 0);
        check("arst_stall", 32'(a_stall), 0);
        check("arst_ctl", 32'(ctl_a), 32'(C_RST));
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
